// File: rtl/dict_codec_pkg.sv
// Shared encodings for the dictionary codec: command/response codes and FSM states.
package dict_codec_pkg;

  typedef enum logic [1:0] {
    CMD_NOP        = 2'b00,
    CMD_COMPRESS   = 2'b01,
    CMD_DECOMPRESS = 2'b10,
    CMD_CLEAR      = 2'b11
  } cmd_e;

  // 2'b11 is reserved and never produced.
  typedef enum logic [1:0] {
    RSP_NONE  = 2'b00,
    RSP_OK    = 2'b01,
    RSP_ERROR = 2'b10
  } rsp_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SEARCH = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

endpackage

// File: rtl/dict_codec_mem.sv
// Dictionary storage: DEPTH x DATA_W, synchronous write, combinational read.
module dict_codec_mem #(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**IDX_W];

  // NOTE: storage has no reset; validity is tracked by the fill counter, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dict_codec.sv
// Dictionary compressor/decompressor: words map to tokens by linear search.
// Optional macro DICT_CODEC_CLEAR_EN makes CLEAR empty the dictionary.
module dict_codec
  import dict_codec_pkg::*;
#(
  parameter int DATA_W = 80,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        command,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic [IDX_W-1:0]  compressed_in,
  output logic [IDX_W-1:0]  compressed_out,
  output logic [DATA_W-1:0] decompressed_out,
  output logic [1:0]        response,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDX_W:0]    fill_count
);

  localparam logic [IDX_W:0] FULL = {1'b1, {IDX_W{1'b0}}};
  localparam logic [IDX_W:0] ONE  = {{IDX_W{1'b0}}, 1'b1};

  state_e            r_state, w_state_nxt;
  logic [IDX_W:0]    r_ptr, r_fill;
  logic [DATA_W-1:0] r_word, r_dec;
  logic [IDX_W-1:0]  r_comp;
  rsp_e              r_rsp;

  logic              w_accept, w_hit, w_ptr_end, w_dec_ok;
  logic              w_we;
  logic [IDX_W-1:0]  w_waddr, w_raddr;
  logic [DATA_W-1:0] w_wdata, w_rdata;

  dict_codec_mem #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // The read port serves the search pointer, and the token input otherwise.
  assign w_raddr   = (r_state == ST_SEARCH) ? r_ptr[IDX_W-1:0] : compressed_in;
  assign w_accept  = cmd_valid && (r_state == ST_IDLE);
  assign w_hit     = (w_rdata == r_word);
  assign w_ptr_end = (r_ptr == r_fill);
  assign w_dec_ok  = ({1'b0, compressed_in} < r_fill);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and write-port control; reset suppresses any in-flight write.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    w_state_nxt = r_state;
    w_we        = 1'b0;
    w_waddr     = r_fill[IDX_W-1:0];
    w_wdata     = r_word;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (cmd_e'(command))
            CMD_COMPRESS: begin
              if (r_fill == '0) begin
                w_we        = 1'b1;
                w_wdata     = data_in;
                w_state_nxt = ST_RESP;
              end else begin
                w_state_nxt = ST_SEARCH;
              end
            end
            CMD_DECOMPRESS: w_state_nxt = ST_RESP;
            CMD_CLEAR:      w_state_nxt = ST_RESP;
            CMD_NOP:        w_state_nxt = ST_IDLE;
            default:        w_state_nxt = ST_IDLE;
          endcase
        end
      end
      ST_SEARCH: begin
        if (w_ptr_end) begin
          w_we        = (r_fill != FULL);
          w_state_nxt = ST_RESP;
        end else if (w_hit) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (!reset) w_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fill <= '0;
      r_ptr  <= '0;
      r_word <= '0;
      r_comp <= '0;
      r_dec  <= '0;
      r_rsp  <= RSP_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ptr  <= '0;
            r_comp <= '0;
            r_dec  <= '0;
            r_rsp  <= RSP_OK;
            case (cmd_e'(command))
              CMD_COMPRESS: begin
                r_word <= data_in;
                if (r_fill == '0) r_fill <= ONE;
              end
              CMD_DECOMPRESS: begin
                if (w_dec_ok) r_dec <= w_rdata;
                else          r_rsp <= RSP_ERROR;
              end
              CMD_CLEAR: begin
`ifdef DICT_CODEC_CLEAR_EN
                r_fill <= '0;
`else
                r_rsp  <= RSP_ERROR;
`endif
              end
              default: ;
            endcase
          end
        end
        ST_SEARCH: begin
          if (w_ptr_end) begin
            if (r_fill != FULL) begin
              r_comp <= r_fill[IDX_W-1:0];
              r_fill <= r_fill + ONE;
            end else begin
              r_rsp  <= RSP_ERROR;
            end
          end else if (w_hit) begin
            r_comp <= r_ptr[IDX_W-1:0];
          end else begin
            r_ptr  <= r_ptr + ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Result registers only reach the ports while a response is presented.
  always_comb begin
    cmd_ready        = (r_state == ST_IDLE);
    rsp_valid        = 1'b0;
    response         = RSP_NONE;
    compressed_out   = '0;
    decompressed_out = '0;
    if (r_state == ST_RESP) begin
      rsp_valid        = 1'b1;
      response         = r_rsp;
      compressed_out   = r_comp;
      decompressed_out = r_dec;
    end
  end

  assign fill_count = r_fill;

endmodule

// File: tb/tb_dict_codec.sv
// Directed scoreboard bench for dict_codec; expectations follow DICT_CODEC_CLEAR_EN.
module tb_dict_codec;
  import dict_codec_pkg::*;

  localparam int DATA_W = 80;
  localparam int IDX_W  = 8;
  localparam int DEPTH  = 2**IDX_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [1:0]        command = 2'b00;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DATA_W-1:0] data_in = '0;
  logic [IDX_W-1:0]  compressed_in = '0;
  logic [IDX_W-1:0]  compressed_out;
  logic [DATA_W-1:0] decompressed_out;
  logic [1:0]        response;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [IDX_W:0]    fill_count;

  always #5 clk = ~clk;

  dict_codec #(.DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .command          (command),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .data_in          (data_in),
    .compressed_in    (compressed_in),
    .compressed_out   (compressed_out),
    .decompressed_out (decompressed_out),
    .response         (response),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .fill_count       (fill_count)
  );

  typedef struct {
    logic [1:0]        rsp;
    logic [IDX_W-1:0]  comp;
    logic [DATA_W-1:0] dec;
    int                lat;
    logic [IDX_W:0]    fill;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drives one command, returning on the first falling edge after acceptance.
  task automatic issue(input logic [1:0] cmd, input logic [DATA_W-1:0] d,
                       input logic [IDX_W-1:0] idx);
    @(negedge clk);
    command = cmd; data_in = d; compressed_in = idx; cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; command = CMD_NOP;
  endtask

  task automatic push_exp(input logic [1:0] rsp, input logic [IDX_W-1:0] comp,
                          input logic [DATA_W-1:0] dec, input int lat,
                          input logic [IDX_W:0] fill);
    exp_t e;
    e.rsp = rsp; e.comp = comp; e.dec = dec; e.lat = lat; e.fill = fill;
    sb.push_back(e);
  endtask

  // Waits for the response, scores it, optionally stalls, then handshakes.
  task automatic collect(input int hold);
    exp_t e;
    int   lat = 1;
    e = sb.pop_front();
    while (!rsp_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("latency", lat, e.lat);
    chk("response", response, e.rsp);
    chk("compressed_out", compressed_out, e.comp);
    chk("decompressed_out", decompressed_out, e.dec);
    chk("fill_count", fill_count, e.fill);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_response", response, e.rsp);
      chk("hold_comp", compressed_out, e.comp);
      chk("hold_dec", decompressed_out, e.dec);
      chk("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rsp_valid", rsp_valid, 0);
    chk("idle_response", response, 0);
    chk("idle_comp", compressed_out, 0);
  endtask

  task automatic compress(input logic [DATA_W-1:0] d, input logic [1:0] rsp,
                          input logic [IDX_W-1:0] tok, input int lat,
                          input logic [IDX_W:0] fill);
    push_exp(rsp, tok, '0, lat, fill);
    issue(CMD_COMPRESS, d, '0);
    collect(0);
  endtask

  task automatic decompress(input logic [IDX_W-1:0] idx, input logic [1:0] rsp,
                            input logic [DATA_W-1:0] word, input logic [IDX_W:0] fill,
                            input int hold);
    push_exp(rsp, '0, word, 1, fill);
    issue(CMD_DECOMPRESS, '0, idx);
    collect(hold);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_response", response, 0);
    chk("rst_comp", compressed_out, 0);
    chk("rst_dec", decompressed_out, 0);
    chk("rst_fill", fill_count, 0);

    // First word lands at index 0 without searching
    compress(80'h1234, RSP_OK, 8'd0, 1, 9'd1);

    // A, B, A: miss with one entry costs fill+2, hit at 0 costs 2
    do_reset();
    compress(80'hA, RSP_OK, 8'd0, 1, 9'd1);
    compress(80'hB, RSP_OK, 8'd1, 3, 9'd2);
    compress(80'hA, RSP_OK, 8'd0, 2, 9'd2);

    decompress(8'd1, RSP_OK, 80'hB, 9'd2, 0);
    decompress(8'd5, RSP_ERROR, '0, 9'd2, 0);
    decompress(8'd2, RSP_ERROR, '0, 9'd2, 0);

    // Back-pressure: response held for 5 cycles
    decompress(8'd0, RSP_OK, 80'hA, 9'd2, 5);

    // NOP is accepted and produces nothing
    issue(CMD_NOP, 80'hFFFF, 8'd1);
    for (int i = 0; i < 3; i++) begin
      chk("nop_rsp_valid", rsp_valid, 0);
      chk("nop_cmd_ready", cmd_ready, 1);
      @(negedge clk);
    end
    chk("nop_fill", fill_count, 2);

    // Reset while searching drops the operation
    issue(CMD_COMPRESS, 80'hC, '0);
    chk("search_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_fill", fill_count, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_quiet", rsp_valid, 0);
    end

    // Fill the whole dictionary
    for (int i = 0; i < DEPTH; i++) begin
      compress(80'h1000 + DATA_W'(i), RSP_OK, IDX_W'(i), (i == 0) ? 1 : i + 2,
               (IDX_W+1)'(i + 1));
    end
    compress(80'h1000 + 80'd200, RSP_OK, 8'd200, 202, 9'd256);
    compress(80'hDEAD, RSP_ERROR, 8'd0, DEPTH + 2, 9'd256);
    decompress(8'd255, RSP_OK, 80'h1000 + 80'd255, 9'd256, 0);

    // CLEAR behaviour depends on build option
`ifdef DICT_CODEC_CLEAR_EN
    push_exp(RSP_OK, '0, '0, 1, 9'd0);
    issue(CMD_CLEAR, '0, '0);
    collect(0);
    decompress(8'd0, RSP_ERROR, '0, 9'd0, 0);
    compress(80'hBEEF, RSP_OK, 8'd0, 1, 9'd1);
`else
    push_exp(RSP_ERROR, '0, '0, 1, 9'd256);
    issue(CMD_CLEAR, '0, '0);
    collect(0);
    decompress(8'd0, RSP_OK, 80'h1000, 9'd256, 0);
`endif

    chk("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
